// File: rtl/jesd_rx_lmfc_align_monitor.sv
// jesd_rx_lmfc_align_monitor
// Receive-side multiframe alignment monitor for one JESD204B lane. Tracks the
// octet index within the local multiframe (restarted by the local LMFC pulse),
// locks the lane's /A/ (K28.3) phase after N_CONFIRM consistent sightings,
// polices /A/ and /F/ (K28.7) placement once aligned, and issues an
// elastic-buffer release pulse on every LMFC boundary while aligned.
//
// Ports:
//   clk          device clock, one octet per cycle
//   rst_n        asynchronous active-low reset
//   i_K          frames per multiframe minus 1 (static while out of reset)
//   i_lmfc_clk   local LMFC pulse, marks octet 0 of each multiframe
//   i_cgs_done   code group sync achieved on this lane
//   i_valid      i_data / i_is_k valid this cycle
//   i_data       decoded octet
//   i_is_k       octet is a control character
//   o_aligned    lane multiframe phase locked
//   o_a_offset   locked octet index of /A/ within the local multiframe
//   o_align_err  one-cycle pulse per alignment violation
//   o_err_cnt    consecutive-violation count (saturating)
//   o_release    one-cycle elastic-buffer release pulse
module jesd_rx_lmfc_align_monitor #(
    parameter int unsigned N_CONFIRM  = 4,
    parameter int unsigned ERR_THRESH = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] i_K,
    input  logic       i_lmfc_clk,
    input  logic       i_cgs_done,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    input  logic       i_is_k,
    output logic       o_aligned,
    output logic [5:0] o_a_offset,
    output logic       o_align_err,
    output logic [3:0] o_err_cnt,
    output logic       o_release
);

    localparam int unsigned IDX_W = 6;
    localparam int unsigned CNT_W = 4;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_7 = 8'hFC;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_A  = 2'd1,
        CONFIRM = 2'd2,
        ALIGNED = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, cur_idx, wrap_idx;
    logic             lmfc_seen_q;
    logic [CNT_W-1:0] confirm_q, confirm_d, confirm_inc;
    logic [IDX_W-1:0] offset_d;
    logic [CNT_W-1:0] err_cnt_d, err_inc;
    logic             align_err_d;
    logic             aligned_d;
    logic             release_d;
    logic             is_a, is_f;
    logic             a_good, f_good;

    // Octet index: restart on LMFC, otherwise free-run and wrap at 2K+1
    always_comb begin
        cur_idx  = i_lmfc_clk ? '0 : idx_q;
        wrap_idx = {i_K, 1'b1};
        idx_d    = (cur_idx == wrap_idx) ? '0 : IDX_W'(cur_idx + IDX_W'(1));
    end

    // Control character decode
    always_comb begin
        is_a   = i_valid && i_is_k && (i_data == K28_3);
        is_f   = i_valid && i_is_k && (i_data == K28_7);
        a_good = (cur_idx == o_a_offset);
        // /F/ closes a frame, so only its parity relative to /A/ is checked
        f_good = (cur_idx[0] == o_a_offset[0]);
    end

    // Saturating increments
    always_comb begin
        err_inc     = (o_err_cnt == CNT_MAX) ? CNT_MAX : CNT_W'(o_err_cnt + CNT_W'(1));
        confirm_inc = (confirm_q == CNT_MAX) ? CNT_MAX : CNT_W'(confirm_q + CNT_W'(1));
    end

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        offset_d    = o_a_offset;
        confirm_d   = confirm_q;
        err_cnt_d   = o_err_cnt;
        align_err_d = 1'b0;

        if ((state_q != IDLE) && !i_cgs_done) begin
            // Losing code group sync overrides any character event
            state_d   = IDLE;
            confirm_d = '0;
            err_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    confirm_d = '0;
                    err_cnt_d = '0;
                    if (i_cgs_done && lmfc_seen_q) begin
                        state_d = WAIT_A;
                    end
                end
                WAIT_A: begin
                    if (is_a) begin
                        offset_d  = cur_idx;
                        confirm_d = CNT_W'(1);
                        state_d   = (N_CONFIRM == 1) ? ALIGNED : CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (is_a) begin
                        if (a_good) begin
                            confirm_d = confirm_inc;
                            if (confirm_inc == CNT_W'(N_CONFIRM)) begin
                                state_d = ALIGNED;
                            end
                        end else begin
                            // Mismatching /A/ is discarded, not taken as a new candidate
                            align_err_d = 1'b1;
                            confirm_d   = '0;
                            state_d     = WAIT_A;
                        end
                    end
                end
                ALIGNED: begin
                    if ((is_a && !a_good) || (is_f && !f_good)) begin
                        align_err_d = 1'b1;
                        if (err_inc >= CNT_W'(ERR_THRESH)) begin
                            err_cnt_d = '0;
                            confirm_d = '0;
                            state_d   = WAIT_A;
                        end else begin
                            err_cnt_d = err_inc;
                        end
                    end else if (is_a) begin
                        err_cnt_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        aligned_d = (state_d == ALIGNED);
        // Uses the current state so no release fires on the entry cycle
        release_d = i_lmfc_clk && (state_q == ALIGNED);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            lmfc_seen_q <= 1'b0;
            confirm_q   <= '0;
            o_aligned   <= 1'b0;
            o_a_offset  <= '0;
            o_align_err <= 1'b0;
            o_err_cnt   <= '0;
            o_release   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            lmfc_seen_q <= lmfc_seen_q | i_lmfc_clk;
            confirm_q   <= confirm_d;
            o_aligned   <= aligned_d;
            o_a_offset  <= offset_d;
            o_align_err <= align_err_d;
            o_err_cnt   <= err_cnt_d;
            o_release   <= release_d;
        end
    end

endmodule

// File: tb/tb_jesd_rx_lmfc_align_monitor.sv
// Directed bench for jesd_rx_lmfc_align_monitor. The bench owns the LMFC
// phase (ph) and drives /A/ and /F/ at chosen octet indices; expected values
// are hand-derived constants.
module tb_jesd_rx_lmfc_align_monitor;

    logic       clk;
    logic       rst_n;
    logic [4:0] i_K;
    logic       i_lmfc_clk;
    logic       i_cgs_done;
    logic       i_valid;
    logic [7:0] i_data;
    logic       i_is_k;
    logic       o_aligned;
    logic [5:0] o_a_offset;
    logic       o_align_err;
    logic [3:0] o_err_cnt;
    logic       o_release;

    int n_assert;
    int n_fail;
    int ph;
    int period;
    bit lmfc_en;

    jesd_rx_lmfc_align_monitor #(
        .N_CONFIRM  (4),
        .ERR_THRESH (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_K         (i_K),
        .i_lmfc_clk  (i_lmfc_clk),
        .i_cgs_done  (i_cgs_done),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_is_k      (i_is_k),
        .o_aligned   (o_aligned),
        .o_a_offset  (o_a_offset),
        .o_align_err (o_align_err),
        .o_err_cnt   (o_err_cnt),
        .o_release   (o_release)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic al, input logic [5:0] off,
                           input logic ae, input logic [3:0] ec, input logic rl);
        chk({tag, ".aligned"}, 8'(o_aligned), 8'(al));
        chk({tag, ".offset"}, 8'(o_a_offset), 8'(off));
        chk({tag, ".align_err"}, 8'(o_align_err), 8'(ae));
        chk({tag, ".err_cnt"}, 8'(o_err_cnt), 8'(ec));
        chk({tag, ".release"}, 8'(o_release), 8'(rl));
    endtask

    // One octet: drive at posedge+1, sampled by the next posedge, observe at +1
    task automatic tick(input logic a, input logic f, input logic v);
        i_lmfc_clk = lmfc_en && (ph == 0);
        i_valid    = v;
        i_is_k     = a | f;
        i_data     = a ? 8'h7C : (f ? 8'hFC : 8'h4A);
        @(posedge clk);
        #1;
        ph = (ph + 1) % period;
    endtask

    // Idle octets until the next octet to be driven sits at index n
    task automatic goto(input int n);
        while (ph != n) tick(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        i_K        = 5'd3;
        period     = 8;
        ph         = 0;
        lmfc_en    = 1'b1;
        i_cgs_done = 1'b1;
        i_lmfc_clk = 1'b0;
        i_valid    = 1'b0;
        i_is_k     = 1'b0;
        i_data     = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 6'd0, 1'b0, 4'd0, 1'b0);
        rst_n = 1'b1;

        // Lock on /A/ at index 7
        for (int m = 0; m < 3; m++) begin
            goto(7);
            tick(1'b1, 1'b0, 1'b1);
            chk("t1_not_yet_aligned", 8'(o_aligned), 8'd0);
        end
        goto(7);
        tick(1'b1, 1'b0, 1'b1);
        chk_all("t1_aligned", 1'b1, 6'd7, 1'b0, 4'd0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        chk("t1_first_release", 8'(o_release), 8'd1);
        tick(1'b0, 1'b0, 1'b1);
        chk("t1_release_one_cycle", 8'(o_release), 8'd0);

        // /F/ placement policing at offset 7
        goto(3);
        tick(1'b0, 1'b1, 1'b1);
        chk_all("t3_f_good", 1'b1, 6'd7, 1'b0, 4'd0, 1'b0);
        goto(2);
        tick(1'b0, 1'b1, 1'b1);
        chk_all("t3_f_bad1", 1'b1, 6'd7, 1'b1, 4'd1, 1'b0);
        goto(2);
        tick(1'b0, 1'b1, 1'b1);
        chk_all("t3_f_bad2", 1'b1, 6'd7, 1'b1, 4'd2, 1'b0);
        goto(7);
        tick(1'b1, 1'b0, 1'b1);
        chk_all("t3_a_good_clears", 1'b1, 6'd7, 1'b0, 4'd0, 1'b0);
        goto(2);
        tick(1'b0, 1'b1, 1'b1);
        chk("t3_cnt_1", 8'(o_err_cnt), 8'd1);
        goto(2);
        tick(1'b0, 1'b1, 1'b1);
        chk("t3_cnt_2", 8'(o_err_cnt), 8'd2);
        goto(2);
        tick(1'b0, 1'b1, 1'b1);
        chk_all("t3_drop", 1'b0, 6'd7, 1'b1, 4'd0, 1'b0);

        // Candidate at 5 broken by /A/ at 6, then lock at 6
        goto(5);
        tick(1'b1, 1'b0, 1'b1);
        chk_all("t2_cand5", 1'b0, 6'd5, 1'b0, 4'd0, 1'b0);
        goto(5);
        tick(1'b1, 1'b0, 1'b1);
        chk_all("t2_cand5_2", 1'b0, 6'd5, 1'b0, 4'd0, 1'b0);
        goto(6);
        tick(1'b1, 1'b0, 1'b1);
        chk_all("t2_mismatch", 1'b0, 6'd5, 1'b1, 4'd0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        chk("t2_err_one_cycle", 8'(o_align_err), 8'd0);
        for (int m = 0; m < 3; m++) begin
            goto(6);
            tick(1'b1, 1'b0, 1'b1);
        end
        chk_all("t2_three_at6", 1'b0, 6'd6, 1'b0, 4'd0, 1'b0);
        goto(6);
        tick(1'b1, 1'b0, 1'b1);
        chk_all("t2_aligned6", 1'b1, 6'd6, 1'b0, 4'd0, 1'b0);

        // Code group sync loss
        i_cgs_done = 1'b0;
        tick(1'b0, 1'b0, 1'b1);
        chk("t4_cgs_drop", 8'(o_aligned), 8'd0);
        i_cgs_done = 1'b1;
        tick(1'b0, 1'b0, 1'b1);
        for (int m = 0; m < 2; m++) begin
            goto(7);
            tick(1'b1, 1'b0, 1'b1);
        end
        chk_all("t4_two_good", 1'b0, 6'd7, 1'b0, 4'd0, 1'b0);
        i_cgs_done = 1'b0;
        tick(1'b0, 1'b0, 1'b1);
        i_cgs_done = 1'b1;
        tick(1'b0, 1'b0, 1'b1);
        for (int m = 0; m < 3; m++) begin
            goto(7);
            tick(1'b1, 1'b0, 1'b1);
        end
        chk("t4_three_after_restart", 8'(o_aligned), 8'd0);
        goto(7);
        tick(1'b1, 1'b0, 1'b1);
        chk_all("t4_realigned", 1'b1, 6'd7, 1'b0, 4'd0, 1'b0);

        // /A/ on the LMFC octet, plus an invalid /A/
        i_cgs_done = 1'b0;
        tick(1'b0, 1'b0, 1'b1);
        i_cgs_done = 1'b1;
        tick(1'b0, 1'b0, 1'b1);
        goto(0);
        tick(1'b1, 1'b0, 1'b1);
        chk_all("t6_offset0", 1'b0, 6'd0, 1'b0, 4'd0, 1'b0);
        goto(0);
        tick(1'b1, 1'b0, 1'b0);
        goto(0);
        tick(1'b1, 1'b0, 1'b1);
        goto(0);
        tick(1'b1, 1'b0, 1'b1);
        chk("t6_invalid_ignored", 8'(o_aligned), 8'd0);
        goto(0);
        tick(1'b1, 1'b0, 1'b1);
        chk_all("t6_aligned_no_release", 1'b1, 6'd0, 1'b0, 4'd0, 1'b0);
        goto(0);
        tick(1'b0, 1'b0, 1'b1);
        chk("t6_release", 8'(o_release), 8'd1);

        // Asynchronous reset while aligned
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("t5_async_reset", 1'b0, 6'd0, 1'b0, 4'd0, 1'b0);
        i_K     = 5'd31;
        period  = 64;
        lmfc_en = 1'b0;
        ph      = 0;
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;

        // No LMFC seen yet: /A/ must not start alignment
        for (int m = 0; m < 10; m++) tick(1'b1, 1'b0, 1'b1);
        chk_all("t5_no_lmfc", 1'b0, 6'd0, 1'b0, 4'd0, 1'b0);

        // K=31: lock at index 63
        lmfc_en = 1'b1;
        ph      = 0;
        goto(63);
        tick(1'b1, 1'b0, 1'b1);
        chk("t5_offset63", 8'(o_a_offset), 8'd63);
        for (int m = 0; m < 3; m++) begin
            goto(63);
            tick(1'b1, 1'b0, 1'b1);
        end
        chk_all("t5_aligned63", 1'b1, 6'd63, 1'b0, 4'd0, 1'b0);

        // Self-wrap without LMFC: index 0 then 1 after 63
        lmfc_en = 1'b0;
        tick(1'b0, 1'b1, 1'b1);
        chk_all("t5_wrap_f_bad", 1'b1, 6'd63, 1'b1, 4'd1, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        chk_all("t5_wrap_f_good", 1'b1, 6'd63, 1'b0, 4'd1, 1'b0);
        goto(63);
        tick(1'b1, 1'b0, 1'b1);
        chk_all("t5_wrap_a_good", 1'b1, 6'd63, 1'b0, 4'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/jesd_rx_lmfc_align_monitor.md
Name: jesd_rx_lmfc_align_monitor

Overview:
- Receive-side counterpart of the frame/LMFC clock generator.
- Consumes the local LMFC pulse and the decoded octet stream of one lane.
- Locks the lane's multiframe phase from /A/ (K28.3) characters, reports its offset against the local LMFC, and polices /A/ and /F/ (K28.7) placement.
- Issues an elastic-buffer release pulse on each LMFC boundary once aligned. Sits between the 8b10b decoder and the lane elastic buffer.

Parameters:
- N_CONFIRM, 4, consecutive correctly phased /A/ needed to declare alignment (1..15).
- ERR_THRESH, 3, consecutive misplaced control characters in ALIGNED before alignment is dropped (1..15).

Ports:
- clk  input  1  device clock; one octet per cycle.
- rst_n  input  1  asynchronous active-low reset.
- i_K  input  5  frames per multiframe minus 1. Static while rst_n is high.
- i_lmfc_clk  input  1  local LMFC pulse, 1 clk wide. Marks octet 0 of each multiframe; period 2*(i_K+1) clk.
- i_cgs_done  input  1  code group sync achieved on this lane.
- i_valid  input  1  i_data and i_is_k are valid this cycle.
- i_data  input  8  decoded octet.
- i_is_k  input  1  octet is a control character.
- o_aligned  output  1  lane multiframe phase locked.
- o_a_offset  output  6  locked octet index of /A/ within the local multiframe.
- o_align_err  output  1  1-cycle pulse on each alignment violation.
- o_err_cnt  output  4  consecutive-violation count, saturating at 15.
- o_release  output  1  1-cycle buffer release pulse.

Behaviour:
- Reset values: all outputs 0; state IDLE; idx_q 0; lmfc_seen 0; confirm counter 0.
- Octet index:
  - cur_idx = 0 when i_lmfc_clk=1, else idx_q.
  - Next idx_q = cur_idx+1, wrapping to 0 after {i_K,1'b1}. Index range is 0..2K+1; max 63 at K=31.
  - lmfc_seen sets on the first i_lmfc_clk and stays set until reset.
  - The index advances every cycle regardless of i_valid.
- Character decode (only when i_valid=1 and i_is_k=1):
  - is_A when i_data = 8'h7C.
  - is_F when i_data = 8'hFC.
  - All other characters are ignored.
- State machine:
  - IDLE -> WAIT_A when i_cgs_done=1 and lmfc_seen=1.
  - WAIT_A:
    - On is_A: o_a_offset <= cur_idx, confirm counter = 1, go to CONFIRM.
    - If N_CONFIRM=1, go directly to ALIGNED instead.
  - CONFIRM:
    - is_A with cur_idx == o_a_offset: increment the confirm counter. On reaching N_CONFIRM, go to ALIGNED.
    - is_A at any other index: o_align_err pulse, go to WAIT_A. The mismatching /A/ is not reused as a new candidate.
    - /F/ is not checked in CONFIRM.
  - ALIGNED:
    - Violations are is_A with cur_idx != o_a_offset, and is_F with cur_idx[0] != o_a_offset[0].
    - On a violation: o_align_err pulse and o_err_cnt+1 (saturating).
    - When the incremented count reaches ERR_THRESH: go to WAIT_A and clear o_err_cnt.
    - A correctly placed /A/ clears o_err_cnt. A correctly placed /F/ leaves it unchanged.
- Deasserting i_cgs_done in any state other than IDLE forces IDLE next cycle. It clears o_aligned, o_err_cnt and the confirm counter. o_a_offset holds its last value.
- Registered outputs, all updated at the clock edge that samples the triggering input:
  - o_aligned = (state == ALIGNED). It rises the cycle after the N_CONFIRM-th good /A/ is sampled.
  - o_align_err is high for exactly the cycle after the offending octet.
  - o_release = i_lmfc_clk && state == ALIGNED (registered). No release fires on the cycle the state enters ALIGNED.
- Simultaneous events:
  - i_cgs_done falling takes priority over any character event.
  - i_lmfc_clk coinciding with /A/ uses cur_idx = 0.
- Asynchronous reset mid-operation returns everything to reset values immediately, including lmfc_seen.

Test Plan:
- i_K=3 (8-octet multiframe); lmfc every 8 clk; cgs_done=1; /A/ at idx 7 for 4 multiframes -> o_a_offset=7, o_aligned rises the cycle after the 4th /A/. The first o_release follows the next lmfc pulse.
- i_K=3; /A/ at idx 5 twice, then at idx 6 -> o_align_err pulses once, o_aligned stays 0, state WAIT_A. Then 4 /A/ at idx 6 -> aligned with o_a_offset=6.
- Aligned at offset 7; /F/ at idx 3 -> no error. /F/ at idx 2 three times -> o_err_cnt 1,2 then o_aligned drops, o_err_cnt=0. A good /A/ between bad /F/s resets the count to 0.
- Drop i_cgs_done after 2 good /A/ -> o_aligned stays 0, confirm counter resets. On reassertion, 4 more /A/ are needed.
- i_K=31; /A/ at idx 63 -> offset 63; idx wraps 63->0 on both lmfc and self-wrap. rst_n low while aligned -> all outputs 0 asynchronously. After release, no alignment until an lmfc pulse is seen.
- i_valid=0 during an /A/ octet -> it is ignored and the confirm count does not advance. An /A/ sampled with i_lmfc_clk=1 is recorded at offset 0.
